// File: rtl/perip_timer_pkg.sv
// perip_timer_pkg: register word indices, CTRL bit positions and reset
// constants shared by the perip_timer block.
package perip_timer_pkg;

    localparam int DATA_BUS = 32;

    typedef logic [4:0] word_t;

    localparam word_t TIMER_TIME_LO  = 5'd0;
    localparam word_t TIMER_TIME_HI  = 5'd1;
    localparam word_t TIMER_CTRL     = 5'd2;
    localparam word_t TIMER_PRESC    = 5'd3;
    localparam word_t TIMER_CMP_BASE = 5'd4;

    localparam int TIMER_CTRL_CNT_EN = 0;
    localparam int TIMER_CTRL_IRQ_EN = 8;

    localparam logic [31:0] CTRL_RST = 32'h0000_0001;

    // Word index of the LO (hi=0) or HI (hi=1) half of compare channel ch.
    function automatic word_t cmp_word(input int ch, input bit hi);
        return word_t'(int'(TIMER_CMP_BASE) + 2 * ch + (hi ? 1 : 0));
    endfunction

endpackage

// File: rtl/perip_timer_prescale.sv
// perip_timer_prescale: divides clk by CLK_DIV, producing a one-cycle tick
// while the count sits at CLK_DIV-1. clr forces the count back to 0.
module perip_timer_prescale #(
    parameter int CLK_DIV = 50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    output logic        tick,
    output logic [15:0] count
);

    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

    logic [15:0] count_q, count_d;

    assign tick  = en && (count_q == LAST);
    assign count = count_q;

    // Next count: clear wins, wrap on tick, hold while disabled.
    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = 16'd0;
        else if (tick)
            count_d = 16'd0;
        else if (en)
            count_d = count_q + 16'd1;
    end

    // Prescaler count register.
    always_ff @(posedge clk) begin
        if (rst)
            count_q <= 16'd0;
        else
            count_q <= count_d;
    end

endmodule

// File: rtl/perip_timer.sv
// perip_timer: 64-bit memory-mapped timer with prescaler, writable time base
// and NUM_CMP compare channels driving registered level interrupts.
// Optional: define PERIP_TIMER_SNAPSHOT_EN so a TIME_LO read latches the
// upper half into a shadow that later TIME_HI reads return.
module perip_timer
    import perip_timer_pkg::*;
#(
    parameter int CLK_DIV = 50,
    parameter int NUM_CMP = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                rw,
    input  logic [DATA_BUS-1:0] addr,
    output logic [DATA_BUS-1:0] rdata,
    input  logic [DATA_BUS-1:0] wdata,
    output logic [NUM_CMP-1:0]  irq
);

    word_t       word;
    logic        wr;
    logic        tick;
    logic        presc_clr;
    logic [15:0] presc;
    logic [63:0] time_q, time_d;
    logic [31:0] ctrl_q, ctrl_d;
    logic [31:0] hi_rd;
    logic [NUM_CMP-1:0][63:0] cmp_all;
    logic        unused_addr;

    assign word        = addr[6:2];
    assign wr          = ena & rw;
    assign unused_addr = ^{addr[DATA_BUS-1:7], addr[1:0]};
    // Any write to the time base restarts the current tick period.
    assign presc_clr   = wr && (word == TIMER_TIME_LO || word == TIMER_TIME_HI);

    perip_timer_prescale #(.CLK_DIV(CLK_DIV)) u_prescale (
        .clk   (clk),
        .rst   (rst),
        .en    (ctrl_q[TIMER_CTRL_CNT_EN]),
        .clr   (presc_clr),
        .tick  (tick),
        .count (presc)
    );

    // Time and CTRL next state; a time write swallows a coincident tick.
    always_comb begin
        time_d = time_q;
        if (wr && word == TIMER_TIME_LO)
            time_d = {time_q[63:32], wdata};
        else if (wr && word == TIMER_TIME_HI)
            time_d = {wdata, time_q[31:0]};
        else if (tick)
            time_d = time_q + 64'd1;
        ctrl_d = (wr && word == TIMER_CTRL) ? wdata : ctrl_q;
    end

    // Time base and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            time_q <= 64'd0;
            ctrl_q <= CTRL_RST;
        end else begin
            time_q <= time_d;
            ctrl_q <= ctrl_d;
        end
    end

`ifdef PERIP_TIMER_SNAPSHOT_EN
    logic [31:0] shadow_q, shadow_d;

    // Capture the upper half on every TIME_LO read.
    always_comb begin
        shadow_d = shadow_q;
        if (ena && !rw && word == TIMER_TIME_LO)
            shadow_d = time_q[63:32];
    end

    // Upper-half shadow register.
    always_ff @(posedge clk) begin
        if (rst)
            shadow_q <= 32'd0;
        else
            shadow_q <= shadow_d;
    end

    assign hi_rd = shadow_q;
`else
    assign hi_rd = time_q[63:32];
`endif

    for (genvar i = 0; i < NUM_CMP; i++) begin : g_cmp
        logic [63:0] cmp_q, cmp_d;
        logic        irq_q, irq_d;

        // Half-word compare writes and the interrupt condition on current values.
        always_comb begin
            cmp_d = cmp_q;
            if (wr && word == cmp_word(i, 1'b0))
                cmp_d[31:0] = wdata;
            if (wr && word == cmp_word(i, 1'b1))
                cmp_d[63:32] = wdata;
            irq_d = ctrl_q[TIMER_CTRL_IRQ_EN + i] & (time_q >= cmp_q);
        end

        // Compare value and registered level interrupt.
        always_ff @(posedge clk) begin
            if (rst) begin
                cmp_q <= '1;
                irq_q <= 1'b0;
            end else begin
                cmp_q <= cmp_d;
                irq_q <= irq_d;
            end
        end

        assign cmp_all[i] = cmp_q;
        assign irq[i]     = irq_q;
    end

    // Zero-latency read mux; unmapped words return 0.
    always_comb begin
        rdata = '0;
        case (word)
            TIMER_TIME_LO: rdata = time_q[31:0];
            TIMER_TIME_HI: rdata = hi_rd;
            TIMER_CTRL:    rdata = ctrl_q;
            TIMER_PRESC:   rdata = {16'd0, presc};
            default: begin
                for (int i = 0; i < NUM_CMP; i++) begin
                    if (word == cmp_word(i, 1'b0))
                        rdata = cmp_all[i][31:0];
                    if (word == cmp_word(i, 1'b1))
                        rdata = cmp_all[i][63:32];
                end
            end
        endcase
    end

endmodule
